// File: rtl/decoder3x8_stream_pkg.sv
// Shared types and helpers for the 3-bit code <-> 8-bit one-hot path.
// The encoder side imports the same package.
package decoder3x8_stream_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned ONEHOT_W = 1 << CODE_W;

    // One buffered request: the enable travels with its code.
    typedef struct packed {
        logic              en;
        logic [CODE_W-1:0] code;
    } entry_t;

    // One-hot decode; a disabled entry decodes to all-zero.
    function automatic logic [ONEHOT_W-1:0] onehot(input logic [CODE_W-1:0] code,
                                                   input logic              en);
        logic [ONEHOT_W-1:0] v;
        v = '0;
        if (en) begin
            v[code] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder3x8_stream_sync_fifo.sv
// Single-clock FIFO with power-of-two depth. The pointers wrap naturally
// and a separate level counter tells full from empty.
module decoder3x8_stream_sync_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Next-state for pointers and occupancy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    // Pointer and level registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage written at the tail.
    // NOTE: storage has no reset; stale contents are unreachable because
    // the cleared level marks every slot empty, and resetting the array
    // would only add a clear path to each storage bit.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/decoder3x8_stream.sv
// Streaming 3-to-8 decoder: buffers {en, code} requests and presents the
// one-hot decode of the oldest one to a downstream that may stall.
module decoder3x8_stream
    import decoder3x8_stream_pkg::*;
#(
    parameter int unsigned N     = CODE_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [N-1:0]           code,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [2**N-1:0]        y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned OUT_W = 2 ** N;

    logic         alive_q;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic [N:0]   head;
    logic [OUT_W-1:0] dec;

    // in_ready stays low during reset and rises on the first clock edge
    // after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    // Handshakes depend only on registered state, never on out_ready.
    assign in_ready  = alive_q && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    decoder3x8_stream_sync_fifo #(
        .WIDTH (N + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({en, code}),
        .pop_i   (pop),
        .rdata_o (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    // Decode the head entry; the shared helper covers the default width.
    generate
        if (N == CODE_W) begin : g_pkg_decode
            entry_t head_entry;
            assign head_entry = entry_t'(head);
            assign dec        = onehot(head_entry.code, head_entry.en);
        end else begin : g_gen_decode
            assign dec = head[N] ? (OUT_W'(1) << head[N-1:0]) : '0;
        end
    endgenerate

    // Nothing leaves the block while the FIFO is empty.
    assign y = out_valid ? dec : '0;

endmodule

// File: doc/decoder3x8_stream.md
Name: decoder3x8_stream

Overview:
- Streaming 3-to-8 one-hot decoder; the receive-side counterpart of the team's 8x3 encoder.
- Accepts 3-bit codes plus an enable through a valid/ready handshake and buffers them in a small FIFO.
- Presents the decoded 8-bit one-hot word on a valid/ready output in arrival order.
- Sits between an encoded control bus and downstream one-hot select logic that can stall.

Parameters:
- N, 3, code width; output width is 2**N (8 at default).
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enable, sampled together with code on input accept.
- code  input  N  binary code to decode.
- in_valid  input  1  code/en are valid.
- in_ready  output  1  block can accept this cycle.
- y  output  2**N  decoded one-hot word at FIFO head.
- out_valid  output  1  y is valid.
- out_ready  input  1  downstream accepts y this cycle.
- level  output  clog2(DEPTH)+1  current number of stored entries.

Behaviour:
- Reset:
  - rst_n low clears the FIFO immediately, independent of clk.
  - While rst_n is low: out_valid=0, y=0, level=0, in_ready=0.
  - in_ready=1 from the first clk edge after rst_n deasserts.
- Input accept:
  - An accept occurs on a rising edge where in_valid && in_ready.
  - {en, code} is written to the tail entry.
  - in_ready = !full (level != DEPTH). It is registered-state-derived and never depends combinationally on out_ready.
- Output pop:
  - A pop occurs on a rising edge where out_valid && out_ready.
  - The head entry is removed.
  - out_valid = (level != 0).
- Decode:
  - y = stored_en ? (1 << stored_code) : 0, taken from the head entry.
  - y is forced to 0 whenever out_valid=0.
  - y is always either exactly one-hot or all-zero.
- Latency: an accepted code appears on y/out_valid on the cycle after the accepting edge. There is no same-cycle pass-through.
- Ordering: strict FIFO. No reordering and no loss.
- Level update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop on the same edge: unchanged.
  - Neither: unchanged.
- Full: in_ready=0, so no push can occur. A pop on a full edge lowers level to DEPTH-1, and in_ready returns high the next cycle.
- Empty: out_valid=0. A push on an empty edge gives out_valid=1 on the next cycle. out_ready while empty has no effect.
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately to distinguish full from empty.
- Stability: while out_valid=1 and out_ready=0, y and out_valid must hold unchanged.
- Input hold: in_valid with in_ready=0 does not drop data. The source must hold code/en until accepted.
- Reset mid-operation: all buffered entries are discarded. No partial output is produced after reset.

Decomposition:
- Shared package, also imported by the encoder side:
  - localparam for default N=3.
  - Function onehot(code, en) returning a 2**N vector.
  - Typedef for the stored entry struct {en, code}.
- Natural sub-module: sync_fifo.
  - Parameterised width/depth storage with pointers, level, full and empty.
  - Storage is not reset; pointers and level are reset.
  - decoder3x8_stream instantiates sync_fifo and applies onehot at the head.

Test Plan:
1. Reset: hold rst_n=0 mid-stream with level=3 -> out_valid=0, y=00000000, level=0 asynchronously. After release and one clk edge, in_ready=1.
2. Full sweep: out_ready=1, en=1, push codes 0..7 back-to-back -> y = 00000001, 00000010, ..., 10000000, each one cycle after accept. level stays at 1 or below.
3. Enable low: push code 5 with en=0 -> out_valid=1 with y=00000000. Next, code 5 with en=1 -> y=00100000.
4. Backpressure: out_ready=0, push codes 1, 2, 3, 4 -> level=4 and in_ready=0. A fifth code 6 is held with no accept. Then raise out_ready=1 -> outputs 00000010, 00000100, 00001000, 00010000, then 01000000. y stays stable while stalled.
5. Simultaneous push/pop at level 2 -> level stays 2 and ordering is preserved. Push/pop on an empty FIFO with out_ready=1 -> no underflow and level=1 after the edge.
6. Wrap-around: 3*DEPTH random codes with random in_valid/out_ready -> a scoreboard shows output order and one-hot values match the expected reference exactly, with no loss or duplication.
